wordle_guess_entry: RTL

Guess-entry controller sitting between the debounced pushbutton pulses and the Wordle game state machine. It lets the player dial a letter A–Z and commit it into a five-slot guess buffer, supports delete, and presents each completed 5-letter guess to the game FSM over a valid/ready handshake. It counts submitted guesses and locks out entry once the guess budget is spent.

---
 rtl/wordle_guess_entry.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/wordle_guess_entry.sv
`default_nettype none
// ============================================================================
// Module   : wordle_guess_entry
// Purpose  : Guess-entry controller for a Wordle game. The player dials a
//            letter A-Z, commits it into a five-slot buffer, can delete the
//            last letter, and submits a full guess to the game FSM over a
//            valid/ready handshake. Submitted guesses are counted, and entry
//            locks once MAX_GUESSES guesses have been accepted.
// Ports    : Clk, reset_n (async, active low), en (game active level),
//            btn_up/btn_down/btn_right/btn_left/btn_center (1-cycle pulses),
//            guess_ready (game FSM accepts guess)
//            -> cur_letter[7:0], cursor[2:0], guess_word[39:0],
//               guess_valid, guess_count[2:0], busy
// Revision : 1.0 - initial release
// ============================================================================
module wordle_guess_entry #(
    parameter int MAX_GUESSES = 6
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_right,
    input  logic        btn_left,
    input  logic        btn_center,
    input  logic        guess_ready,
    output logic [7:0]  cur_letter,
    output logic [2:0]  cursor,
    output logic [39:0] guess_word,
    output logic        guess_valid,
    output logic [2:0]  guess_count,
    output logic        busy
);

    localparam logic [7:0] c_SPACE  = 8'h20;
    localparam logic [7:0] c_LET_A  = 8'h41;
    localparam logic [7:0] c_LET_Z  = 8'h5A;
    localparam logic [2:0] c_SLOTS  = 3'd5;
    localparam logic [2:0] c_MAX_GUESSES = 3'(MAX_GUESSES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_SUBMIT = 2'd2,
        ST_LOCK   = 2'd3
    } state_t;

    state_t     r_state;
    logic [7:0] r_letter;
    logic [2:0] r_cursor;
    logic [7:0] r_slot [0:4];
    logic       r_valid;
    logic [2:0] r_count;
    logic       r_busy;

    logic [2:0] w_del_idx;
    logic [2:0] w_count_inc;

    assign w_del_idx   = r_cursor - 3'd1;
    // Saturating increment so the count can never pass the budget.
    assign w_count_inc = (r_count < c_MAX_GUESSES) ? r_count + 3'd1 : r_count;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_letter <= c_LET_A;
            r_cursor <= 3'd0;
            for (int i = 0; i < 5; i++) r_slot[i] <= c_SPACE;
            r_valid  <= 1'b0;
            r_count  <= 3'd0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        // New game: wipe the buffer and the guess budget.
                        r_state  <= ST_EDIT;
                        r_letter <= c_LET_A;
                        r_cursor <= 3'd0;
                        for (int i = 0; i < 5; i++) r_slot[i] <= c_SPACE;
                        r_count  <= 3'd0;
                    end
                end

                ST_EDIT: begin
                    if (!en) begin
                        r_state <= ST_IDLE;
                    end else if (btn_center) begin
                        if (r_cursor == c_SLOTS) begin
                            r_state <= ST_SUBMIT;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end else if (btn_left) begin
                        if (r_cursor != 3'd0) begin
                            r_cursor <= w_del_idx;
                            for (int i = 0; i < 5; i++)
                                if (w_del_idx == 3'(i)) r_slot[i] <= c_SPACE;
                        end
                    end else if (btn_right) begin
                        if (r_cursor < c_SLOTS) begin
                            r_cursor <= r_cursor + 3'd1;
                            for (int i = 0; i < 5; i++)
                                if (r_cursor == 3'(i)) r_slot[i] <= r_letter;
                        end
                    end else if (btn_up) begin
                        r_letter <= (r_letter == c_LET_Z) ? c_LET_A : r_letter + 8'd1;
                    end else if (btn_down) begin
                        r_letter <= (r_letter == c_LET_A) ? c_LET_Z : r_letter - 8'd1;
                    end
                end

                ST_SUBMIT: begin
                    // Abort has priority over a transfer in the same cycle.
                    if (!en) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_valid && guess_ready) begin
                        r_valid  <= 1'b0;
                        r_busy   <= 1'b0;
                        r_count  <= w_count_inc;
                        r_letter <= c_LET_A;
                        r_cursor <= 3'd0;
                        for (int i = 0; i < 5; i++) r_slot[i] <= c_SPACE;
                        r_state  <= (w_count_inc == c_MAX_GUESSES) ? ST_LOCK : ST_EDIT;
                    end
                end

                ST_LOCK: begin
                    if (!en) r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cur_letter  = r_letter;
    assign cursor      = r_cursor;
    assign guess_word  = {r_slot[0], r_slot[1], r_slot[2], r_slot[3], r_slot[4]};
    assign guess_valid = r_valid;
    assign guess_count = r_count;
    assign busy        = r_busy;

endmodule
`default_nettype wire
